gpr_file: RTL and testbench
===========================

// Module: gpr_file
// PURPOSE
//  General-purpose register file: the write-back sink for WB-stage results (wr_data_wb/wr_valid_wb).
//  Provides two read ports for the decode stage, forwarding the same-cycle WB write onto those ports.
//  Holds a load-pending scoreboard: flags a RAW stall while decode reads a register with an outstanding load.
//  Sits between the WB stage and the decode/issue logic.
// PARAMETERS
//  DATA_WIDTH  32  register / data width (matches `DATA_WIDTH)
//  ADDR_WIDTH  5   register index width
//  NUM_REGS    32  number of architectural registers; x0 is hard-wired to zero
// PORTS
//  cpu_clk        in   1           cpu clock, all state on rising edge
//  cpu_rstn       in   1           asynchronous reset, active low
//  wr_data_wb     in   DATA_WIDTH  final write-back data from WB stage
//  wr_valid_wb    in   1           write-back valid
//  rd_wb          in   ADDR_WIDTH  write-back destination register
//  wb_is_load     in   1           current write-back is load data (retires scoreboard entry)
//  load_issue     in   1           a load leaves decode this cycle
//  load_rd        in   ADDR_WIDTH  destination register of the issuing load
//  flush          in   1           pipeline flush: squash all outstanding-load tracking
//  rs1_addr       in   ADDR_WIDTH  read port 1 address
//  rs1_used       in   1           decoded instruction actually reads rs1
//  rs2_addr       in   ADDR_WIDTH  read port 2 address
//  rs2_used       in   1           decoded instruction actually reads rs2
//  rs1_data       out  DATA_WIDTH  read port 1 data (combinational)
//  rs2_data       out  DATA_WIDTH  read port 2 data (combinational)
//  raw_stall      out  1           decode must hold: an operand waits on an outstanding load
//  load_pend_cnt  out  ADDR_WIDTH+1  count of registers with a pending load (registered)
// BEHAVIOUR
//  Reset (cpu_rstn=0, async): all registers 0, all pending bits 0, load_pend_cnt 0.
//   => rs1_data = rs2_data = 0 and raw_stall = 0 while in reset.
//  Write:
//   - rising edge with wr_valid_wb=1 and rd_wb!=0: regs[rd_wb] <= wr_data_wb.
//   - Writes to x0 are dropped.
//  Read (zero latency):
//   - rsN_addr==0 -> rsN_data = 0.
//   - else if wr_valid_wb && rd_wb==rsN_addr -> rsN_data = wr_data_wb (WB bypass).
//   - else rsN_data = regs[rsN_addr].
//  Scoreboard: pending[NUM_REGS], bit 0 tied to 0. Next-state, in priority order:
//   1. flush=1 -> all bits cleared; a load_issue in the same cycle is ignored.
//   2. load_issue && load_rd!=0 -> set pending[load_rd].
//   3. wr_valid_wb && wb_is_load && rd_wb!=0 -> clear pending[rd_wb],
//      unless rule 2 sets the same register this cycle (newer load wins; bit stays set).
//   - Set and clear of different registers in one cycle both take effect.
//  raw_stall (combinational), per port N:
//   - asserted when rsN_used && rsN_addr!=0 && pending[rsN_addr]
//   - and NOT (wr_valid_wb && wb_is_load && rd_wb==rsN_addr),
//     i.e. the load data arriving this cycle releases the stall via bypass.
//   - raw_stall = OR over both ports.
//  load_pend_cnt: registered popcount of next-state pending.
//   - Max NUM_REGS-1; no wrap possible.
// TESTING
//  - Reset mid-run with regs written and pending set -> next cycle all reads 0, raw_stall=0, cnt=0.
//  - WB x5<=0xDEADBEEF, rs1_addr=5 in same cycle -> rs1_data=0xDEADBEEF same cycle;
//    next cycle read from array, still 0xDEADBEEF.
//  - WB x0<=0x1234, rs2_addr=0 -> rs2_data=0 same and later cycles.
//  - load_issue x7; next cycle rs1_addr=7, rs1_used=1 -> raw_stall=1, cnt=1;
//    load WB x7=0x55 -> raw_stall=0, rs1_data=0x55 that cycle; then cnt=0.
//  - Same-cycle load WB x7 and new load_issue x7 -> pending[7] stays 1, cnt unchanged;
//    rs2_used=0 with rs2_addr=7 never stalls.
//  - Loads pending on x3,x4 then flush with load_issue x9 -> all pending 0, cnt=0, no stall on x3/x4/x9.

Source files
------------

// File: rtl/gpr_file.sv
// General-purpose register file: WB write sink, two bypassed decode read ports,
// and a load-pending scoreboard that raises a RAW stall on outstanding loads.
module gpr_file #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_REGS   = 32
) (
    input  logic                  cpu_clk,
    input  logic                  cpu_rstn,
    input  logic [DATA_WIDTH-1:0] wr_data_wb,
    input  logic                  wr_valid_wb,
    input  logic [ADDR_WIDTH-1:0] rd_wb,
    input  logic                  wb_is_load,
    input  logic                  load_issue,
    input  logic [ADDR_WIDTH-1:0] load_rd,
    input  logic                  flush,
    input  logic [ADDR_WIDTH-1:0] rs1_addr,
    input  logic                  rs1_used,
    input  logic [ADDR_WIDTH-1:0] rs2_addr,
    input  logic                  rs2_used,
    output logic [DATA_WIDTH-1:0] rs1_data,
    output logic [DATA_WIDTH-1:0] rs2_data,
    output logic                  raw_stall,
    output logic [ADDR_WIDTH:0]   load_pend_cnt
);

    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [NUM_REGS-1:0]   pend_q, pend_d;
    logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
    logic                  wb_wr, wb_ld_ret;
    logic                  stall1, stall2;

    assign wb_wr     = wr_valid_wb && (rd_wb != '0);
    assign wb_ld_ret = wb_wr && wb_is_load;

    // Clear is applied before set so a same-cycle reissue to the same register keeps the bit.
    always_comb begin
        pend_d = pend_q;
        if (flush) begin
            pend_d = '0;
        end else begin
            if (wb_ld_ret)
                pend_d[rd_wb] = 1'b0;
            if (load_issue && (load_rd != '0))
                pend_d[load_rd] = 1'b1;
        end
        pend_d[0] = 1'b0;
    end

    always_comb begin
        cnt_d = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++)
            cnt_d = cnt_d + (ADDR_WIDTH+1)'(pend_d[i]);
    end

    always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
        if (!cpu_rstn) begin
            for (int unsigned i = 0; i < NUM_REGS; i++)
                regs_q[i] <= '0;
        end else if (wb_wr) begin
            regs_q[rd_wb] <= wr_data_wb;
        end
    end

    always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
        if (!cpu_rstn) begin
            pend_q <= '0;
            cnt_q  <= '0;
        end else begin
            pend_q <= pend_d;
            cnt_q  <= cnt_d;
        end
    end

    always_comb begin
        rs1_data = regs_q[rs1_addr];
        if (rs1_addr == '0)
            rs1_data = '0;
        else if (wr_valid_wb && (rd_wb == rs1_addr))
            rs1_data = wr_data_wb;
    end

    always_comb begin
        rs2_data = regs_q[rs2_addr];
        if (rs2_addr == '0)
            rs2_data = '0;
        else if (wr_valid_wb && (rd_wb == rs2_addr))
            rs2_data = wr_data_wb;
    end

    // Load data landing this cycle reaches decode through the bypass, so it releases the stall.
    always_comb begin
        stall1 = rs1_used && (rs1_addr != '0) && pend_q[rs1_addr]
                 && !(wr_valid_wb && wb_is_load && (rd_wb == rs1_addr));
        stall2 = rs2_used && (rs2_addr != '0) && pend_q[rs2_addr]
                 && !(wr_valid_wb && wb_is_load && (rd_wb == rs2_addr));
    end

    assign raw_stall     = stall1 || stall2;
    assign load_pend_cnt = cnt_q;

endmodule

// File: tb/tb_gpr_file.sv
// Self-checking bench for gpr_file: directed scenarios plus randomized traffic
// compared against an array-based reference model.
module tb_gpr_file;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] wd;
    logic        wv, wbl, li, fl, u1, u2;
    logic [4:0]  rd, lrd, a1, a2;
    logic [31:0] d1, d2;
    logic        stall;
    logic [5:0]  cnt;

    int total = 0;
    int bad   = 0;

    bit [31:0] m_regs [32];
    bit [31:0] m_pend;
    int        m_cnt;

    always #5 clk = ~clk;

    gpr_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_REGS(32)) dut (
        .cpu_clk(clk), .cpu_rstn(rst_n),
        .wr_data_wb(wd), .wr_valid_wb(wv), .rd_wb(rd), .wb_is_load(wbl),
        .load_issue(li), .load_rd(lrd), .flush(fl),
        .rs1_addr(a1), .rs1_used(u1), .rs2_addr(a2), .rs2_used(u2),
        .rs1_data(d1), .rs2_data(d2), .raw_stall(stall), .load_pend_cnt(cnt)
    );

    // Reference model: architectural state as plain arrays/bit-sets.
    function automatic bit [31:0] next_pend();
        bit [31:0] p = m_pend;
        if (fl) return 32'd0;
        if (wv && wbl && rd != 0) p[rd] = 1'b0;
        if (li && lrd != 0) p[lrd] = 1'b1;
        return p;
    endfunction

    function automatic bit [31:0] exp_read(input bit [4:0] a);
        if (a == 0) return 32'd0;
        if (wv && rd == a) return wd;
        return m_regs[a];
    endfunction

    function automatic bit exp_stall();
        bit s = 1'b0;
        if (u1 && a1 != 0 && m_pend[a1] && !(wv && wbl && rd == a1)) s = 1'b1;
        if (u2 && a2 != 0 && m_pend[a2] && !(wv && wbl && rd == a2)) s = 1'b1;
        return s;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) m_regs[i] <= 32'd0;
            m_pend <= 32'd0;
            m_cnt  <= 0;
        end else begin
            if (wv && rd != 0) m_regs[rd] <= wd;
            m_pend <= next_pend();
            m_cnt  <= $countones(next_pend());
        end
    end

    task automatic idle();
        wd = 32'd0; wv = 1'b0; rd = 5'd0; wbl = 1'b0; li = 1'b0; lrd = 5'd0; fl = 1'b0;
        a1 = 5'd0; u1 = 1'b0; a2 = 5'd0; u2 = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        idle();
        rst_n = 1'b0;
        a1 = 5'd3; a2 = 5'd9; u1 = 1'b1; u2 = 1'b1;
        #1;
        total++; if (d1 !== 32'd0)  begin bad++; $display("FAIL reset_rs1 got=%h exp=0", d1); end
        total++; if (d2 !== 32'd0)  begin bad++; $display("FAIL reset_rs2 got=%h exp=0", d2); end
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b exp=0", stall); end
        total++; if (cnt !== 6'd0)  begin bad++; $display("FAIL reset_cnt got=%0d exp=0", cnt); end
        @(negedge clk);
        rst_n = 1'b1;
        idle();
    endtask

    task automatic test_bypass();
        do_reset();
        wv = 1'b1; rd = 5'd5; wd = 32'hDEADBEEF; a1 = 5'd5;
        #1;
        total++; if (d1 !== 32'hDEADBEEF) begin bad++; $display("FAIL bypass_same got=%h exp=deadbeef", d1); end
        @(negedge clk);
        idle(); a1 = 5'd5;
        #1;
        total++; if (d1 !== 32'hDEADBEEF) begin bad++; $display("FAIL bypass_array got=%h exp=deadbeef", d1); end
    endtask

    task automatic test_x0();
        @(negedge clk);
        idle(); wv = 1'b1; rd = 5'd0; wd = 32'h1234; a2 = 5'd0;
        #1;
        total++; if (d2 !== 32'd0) begin bad++; $display("FAIL x0_same got=%h exp=0", d2); end
        @(negedge clk);
        idle(); a2 = 5'd0;
        #1;
        total++; if (d2 !== 32'd0) begin bad++; $display("FAIL x0_later got=%h exp=0", d2); end
    endtask

    task automatic test_load_stall();
        do_reset();
        li = 1'b1; lrd = 5'd7;
        @(negedge clk);
        idle(); a1 = 5'd7; u1 = 1'b1;
        #1;
        total++; if (stall !== 1'b1) begin bad++; $display("FAIL ld_stall got=%b exp=1", stall); end
        total++; if (cnt !== 6'd1)   begin bad++; $display("FAIL ld_cnt1 got=%0d exp=1", cnt); end
        @(negedge clk);
        wv = 1'b1; wbl = 1'b1; rd = 5'd7; wd = 32'h55;
        #1;
        total++; if (stall !== 1'b0)  begin bad++; $display("FAIL ld_release got=%b exp=0", stall); end
        total++; if (d1 !== 32'h55)   begin bad++; $display("FAIL ld_bypass got=%h exp=55", d1); end
        @(negedge clk);
        idle(); a1 = 5'd7; u1 = 1'b1;
        #1;
        total++; if (cnt !== 6'd0)   begin bad++; $display("FAIL ld_cnt0 got=%0d exp=0", cnt); end
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL ld_nostall got=%b exp=0", stall); end
        total++; if (d1 !== 32'h55)  begin bad++; $display("FAIL ld_array got=%h exp=55", d1); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        li = 1'b1; lrd = 5'd7;
        @(negedge clk);
        idle();
        wv = 1'b1; wbl = 1'b1; rd = 5'd7; wd = 32'h77; li = 1'b1; lrd = 5'd7;
        a2 = 5'd7; u2 = 1'b0;
        #1;
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL b2b_unused got=%b exp=0", stall); end
        total++; if (cnt !== 6'd1)   begin bad++; $display("FAIL b2b_cnt_before got=%0d exp=1", cnt); end
        @(negedge clk);
        idle(); a2 = 5'd7; u2 = 1'b0;
        #1;
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL b2b_unused2 got=%b exp=0", stall); end
        total++; if (cnt !== 6'd1)   begin bad++; $display("FAIL b2b_cnt got=%0d exp=1", cnt); end
        u2 = 1'b1;
        #1;
        total++; if (stall !== 1'b1) begin bad++; $display("FAIL b2b_still_pend got=%b exp=1", stall); end
    endtask

    task automatic test_flush();
        do_reset();
        li = 1'b1; lrd = 5'd3;
        @(negedge clk);
        lrd = 5'd4;
        @(negedge clk);
        idle(); fl = 1'b1; li = 1'b1; lrd = 5'd9;
        #1;
        total++; if (cnt !== 6'd2) begin bad++; $display("FAIL flush_cnt_before got=%0d exp=2", cnt); end
        @(negedge clk);
        idle(); a1 = 5'd3; u1 = 1'b1; a2 = 5'd4; u2 = 1'b1;
        #1;
        total++; if (cnt !== 6'd0)   begin bad++; $display("FAIL flush_cnt got=%0d exp=0", cnt); end
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL flush_stall34 got=%b exp=0", stall); end
        a1 = 5'd9;
        #1;
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL flush_stall9 got=%b exp=0", stall); end
    endtask

    task automatic test_reset_midrun();
        do_reset();
        wv = 1'b1; rd = 5'd12; wd = 32'hA5A5_0001; li = 1'b1; lrd = 5'd13;
        @(negedge clk);
        idle(); a1 = 5'd12; a2 = 5'd13; u2 = 1'b1;
        #1;
        total++; if (d1 !== 32'hA5A5_0001) begin bad++; $display("FAIL mid_pre_rd got=%h exp=a5a50001", d1); end
        total++; if (stall !== 1'b1)      begin bad++; $display("FAIL mid_pre_stall got=%b exp=1", stall); end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        total++; if (d1 !== 32'd0)   begin bad++; $display("FAIL mid_rd got=%h exp=0", d1); end
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL mid_stall got=%b exp=0", stall); end
        total++; if (cnt !== 6'd0)   begin bad++; $display("FAIL mid_cnt got=%0d exp=0", cnt); end
    endtask

    function automatic bit [4:0] rnd_addr();
        // Narrow range most of the time so writes, loads and reads collide often.
        if ($urandom_range(0, 3) != 0) return 5'($urandom_range(0, 7));
        return 5'($urandom_range(0, 31));
    endfunction

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            wd  = $urandom;
            wv  = ($urandom_range(0, 1) == 1);
            rd  = rnd_addr();
            wbl = ($urandom_range(0, 2) != 0);
            li  = ($urandom_range(0, 1) == 1);
            lrd = rnd_addr();
            fl  = ($urandom_range(0, 15) == 0);
            a1  = rnd_addr(); u1 = ($urandom_range(0, 3) != 0);
            a2  = rnd_addr(); u2 = ($urandom_range(0, 3) != 0);
            #1;
            total++; if (d1 !== exp_read(a1)) begin bad++; $display("FAIL rnd_rs1 n=%0d got=%h exp=%h", n, d1, exp_read(a1)); end
            total++; if (d2 !== exp_read(a2)) begin bad++; $display("FAIL rnd_rs2 n=%0d got=%h exp=%h", n, d2, exp_read(a2)); end
            total++; if (stall !== exp_stall()) begin bad++; $display("FAIL rnd_stall n=%0d got=%b exp=%b", n, stall, exp_stall()); end
            total++; if (int'(cnt) != m_cnt) begin bad++; $display("FAIL rnd_cnt n=%0d got=%0d exp=%0d", n, cnt, m_cnt); end
        end
        idle();
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        test_reset();
        test_bypass();
        test_x0();
        test_load_stall();
        test_back_to_back();
        test_flush();
        test_reset_midrun();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
